// File: rtl/multdiv_unit.sv
// Iterative unsigned multiply/divide unit owning the HI/LO register pair.
// MULTU uses shift-add and DIVU uses restoring division. Each runs one radix-2 step
// per clock for WIDTH clocks. MTHI/MTLO write HI/LO directly.
// All outputs come straight from flops.
// WIDTH must be at least 2.
module multdiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] OpMultu = 2'b00;
    localparam logic [1:0] OpDivu  = 2'b01;
    localparam logic [1:0] OpMthi  = 2'b10;
    localparam logic [1:0] OpMtlo  = 2'b11;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e             state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    // Multiplicand (MULTU), divisor (DIVU) or dividend (DIVU by zero).
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               is_div_q, is_div_d;
    // DIVU by zero: the result is written on the edge after entry into StDone.
    logic               zero_pend_q, zero_pend_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] step_next;
    logic               accept;

    // One radix-2 step of each algorithm on the shared accumulator.
    always_comb begin
        // Multiply: acc = {partial product, remaining multiplier bits}.
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};
        // Divide: acc = {partial remainder, dividend bits shifting into quotient bits}.
        div_diff = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_q};
        if (div_diff[WIDTH]) begin
            div_next = {acc_q[2*WIDTH-2:0], 1'b0};
        end else begin
            div_next = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end
        step_next = is_div_q ? div_next : mul_next;
    end

    // Next-state and output logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        opnd_d      = opnd_q;
        is_div_d    = is_div_q;
        zero_pend_d = zero_pend_q;
        done_d      = 1'b0;
        hi_d        = hi_q;
        lo_d        = lo_q;
        accept      = 1'b0;

        unique case (state_q)
            StIdle: begin
                accept = start;
            end
            StRun: begin
                acc_d = step_next;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    hi_d    = step_next[2*WIDTH-1:WIDTH];
                    lo_d    = step_next[WIDTH-1:0];
                    done_d  = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (zero_pend_q) begin
                    // Finish the divide-by-zero write; later requests are taken next cycle.
                    hi_d        = opnd_q;
                    lo_d        = {WIDTH{1'b1}};
                    done_d      = 1'b1;
                    zero_pend_d = 1'b0;
                end else begin
                    state_d = StIdle;
                    accept  = start;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (accept) begin
            unique case (op)
                OpMultu: begin
                    acc_d    = {{WIDTH{1'b0}}, b};
                    opnd_d   = a;
                    is_div_d = 1'b0;
                    cnt_d    = CntW'(WIDTH - 1);
                    state_d  = StRun;
                end
                OpDivu: begin
                    if (b == '0) begin
                        opnd_d      = a;
                        zero_pend_d = 1'b1;
                        state_d     = StDone;
                    end else begin
                        acc_d    = {{WIDTH{1'b0}}, a};
                        opnd_d   = b;
                        is_div_d = 1'b1;
                        cnt_d    = CntW'(WIDTH - 1);
                        state_d  = StRun;
                    end
                end
                OpMthi: hi_d = a;
                OpMtlo: lo_d = a;
                default: ;
            endcase
        end

        busy_d = (state_d == StRun);
    end

    // State and output registers; reset clears everything at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            acc_q       <= '0;
            opnd_q      <= '0;
            is_div_q    <= 1'b0;
            zero_pend_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            opnd_q      <= opnd_d;
            is_div_q    <= is_div_d;
            zero_pend_q <= zero_pend_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_multdiv_unit.sv
// Directed testbench for multdiv_unit with hand-computed expected values.
module tb_multdiv_unit;

    localparam int unsigned W = 32;

    logic         clk;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int checks   = 0;
    int failures = 0;

    multdiv_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge and land on the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic issue(input logic [1:0] o, input logic [W-1:0] av, input logic [W-1:0] bv);
        start = 1'b1;
        op    = o;
        a     = av;
        b     = bv;
        step();
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        #12;
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_done", {31'b0, done}, 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        step();

        // MTHI then MTLO on consecutive cycles.
        start = 1'b1; op = 2'b10; a = 32'hDEADBEEF;
        step();
        chk("mthi_hi", hi, 32'hDEADBEEF);
        chk("mthi_done", {31'b0, done}, 32'd0);
        chk("mthi_busy", {31'b0, busy}, 32'd0);
        op = 2'b11; a = 32'hCAFEF00D;
        step();
        start = 1'b0;
        chk("mtlo_lo", lo, 32'hCAFEF00D);
        chk("mtlo_hi", hi, 32'hDEADBEEF);
        chk("mtlo_done", {31'b0, done}, 32'd0);
        step();
        chk("mtlo_done_later", {31'b0, done}, 32'd0);

        // MULTU max*max: busy for 32 cycles, hi/lo hold until the final edge.
        issue(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
        for (int k = 1; k < 32; k++) begin
            chk("mul_run_busy", {31'b0, busy}, 32'd1);
            chk("mul_run_done", {31'b0, done}, 32'd0);
            chk("mul_run_hi", hi, 32'hDEADBEEF);
            chk("mul_run_lo", lo, 32'hCAFEF00D);
            step();
        end
        chk("mul_run_last_busy", {31'b0, busy}, 32'd1);
        step();
        chk("mul_done", {31'b0, done}, 32'd1);
        chk("mul_busy_off", {31'b0, busy}, 32'd0);
        chk("mul_hi", hi, 32'hFFFFFFFE);
        chk("mul_lo", lo, 32'h00000001);
        step();
        chk("mul_done_fall", {31'b0, done}, 32'd0);

        // DIVU 100/7.
        issue(2'b01, 32'd100, 32'd7);
        for (int k = 1; k < 32; k++) begin
            chk("div_run_busy", {31'b0, busy}, 32'd1);
            chk("div_run_hi", hi, 32'hFFFFFFFE);
            chk("div_run_lo", lo, 32'h00000001);
            step();
        end
        step();
        chk("div_done", {31'b0, done}, 32'd1);
        chk("div_lo", lo, 32'd14);
        chk("div_hi", hi, 32'd2);
        step();
        chk("div_done_fall", {31'b0, done}, 32'd0);

        // DIVU by zero: no RUN phase, result one edge after issue.
        issue(2'b01, 32'h12345678, 32'd0);
        chk("dz_e0_busy", {31'b0, busy}, 32'd0);
        chk("dz_e0_done", {31'b0, done}, 32'd0);
        chk("dz_e0_lo", lo, 32'd14);
        step();
        chk("dz_done", {31'b0, done}, 32'd1);
        chk("dz_busy", {31'b0, busy}, 32'd0);
        chk("dz_lo", lo, 32'hFFFFFFFF);
        chk("dz_hi", hi, 32'h12345678);
        step();
        chk("dz_done_fall", {31'b0, done}, 32'd0);
        step();

        // MULTU 3*5 with an ignored DIVU 9/3 request in the middle.
        issue(2'b00, 32'd3, 32'd5);
        for (int k = 1; k < 10; k++) step();
        issue(2'b01, 32'd9, 32'd3);
        for (int k = 11; k < 32; k++) begin
            chk("ign_busy", {31'b0, busy}, 32'd1);
            step();
        end
        chk("ign_done_early", {31'b0, done}, 32'd0);
        step();
        chk("ign_done", {31'b0, done}, 32'd1);
        chk("ign_hi", hi, 32'd0);
        chk("ign_lo", lo, 32'd15);
        step();
        chk("ign_idle_done", {31'b0, done}, 32'd0);
        chk("ign_idle_busy", {31'b0, busy}, 32'd0);

        // Asynchronous reset in the middle of a MULTU.
        issue(2'b00, 32'd7, 32'd9);
        for (int k = 1; k < 6; k++) step();
        chk("rst_pre_busy", {31'b0, busy}, 32'd1);
        #1 reset = 1'b0;
        #1;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 40; k++) begin
            chk("rst_after_done", {31'b0, done}, 32'd0);
            step();
        end
        chk("rst_after_busy", {31'b0, busy}, 32'd0);
        chk("rst_after_hi", hi, 32'd0);
        chk("rst_after_lo", lo, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
